// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory stage: RV32I load/store funct3 codes,
// the access FSM state type and the access legality check.
package riscv_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    // funct3[1:0] encodes the access size for both loads and stores (0=byte, 1=half, 2=word).
    function automatic logic access_fault(input logic       is_store,
                                          input logic [2:0] funct3,
                                          input logic [1:0] offset);
        logic illegal;
        logic misaligned;
        illegal    = is_store ? (funct3 > 3'd2)
                              : (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7);
        misaligned = (funct3[1:0] == 2'd1 && offset[0]) ||
                     (funct3[1:0] == 2'd2 && offset != 2'd0);
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// Word-organised SRAM with per-byte write enables, synchronous write and a
// registered read; one access per enabled cycle.
module dmem_sram #(
    parameter int DEPTH = 128,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_unit.sv
// Data-memory stage: accepts one load/store at a time, stalls the pipeline for
// LAT+1 cycles, then retires with extended load data or flags a bad access.
module dmem_unit
    import riscv_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 128,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [2:0]        mem_funct3,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              stall,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              fault,
    output dmem_state_t       dbg_state
);

    localparam int         IDX_W    = ADDR_W - 2;
    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    // Handshake: a request (mem_rd|mem_wr) is held while stall is high; it is
    // accepted in IDLE, and retires with a one-cycle rsp_valid (or fault) pulse
    // in a cycle where stall is low. Nothing is accepted while reset is high.
    dmem_state_t       state_q, state_d;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        f3_q;
    logic [31:0]       wdata_q;
    logic              store_q;

    logic        req;
    logic        req_fault;
    logic        accept;
    logic        fire;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] sram_rdata;
    logic [31:0] byte_word;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    assign req       = mem_rd | mem_wr;
    assign req_fault = access_fault(mem_wr, mem_funct3, mem_addr[1:0]);
    assign accept    = !reset && state_q == IDLE && req && !req_fault;
    assign fire      = !reset && state_q == BUSY && cnt_q == 4'd0;
    assign dbg_state = state_q;

    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        fault     = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && !reset) begin
                    if (req_fault) begin
                        fault = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                stall = !reset;
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                rsp_valid = !reset;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            f3_q    <= 3'd0;
            wdata_q <= 32'd0;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= mem_addr;
                f3_q    <= mem_funct3;
                wdata_q <= mem_wdata;
                store_q <= mem_wr;
                cnt_q   <= CNT_INIT;
            end else if (state_q == BUSY && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    // Store data is replicated across lanes so the byte enables alone pick the target lanes.
    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = wdata_q;
        case (f3_q[1:0])
            2'd0: begin
                lane_be    = 4'b0001 << addr_q[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                lane_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    dmem_sram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_sram (
        .clk   (clk),
        .en    (fire),
        .be    (store_q ? lane_be : 4'b0000),
        .idx   (addr_q[ADDR_W-1:2]),
        .wdata (lane_wdata),
        .rdata (sram_rdata)
    );

    assign byte_word = sram_rdata >> {addr_q[1:0], 3'b000};
    assign half_sel  = addr_q[1] ? sram_rdata[31:16] : sram_rdata[15:0];

    always_comb begin
        load_ext = 32'd0;
        case (f3_q)
            F3_LB:   load_ext = {{24{byte_word[7]}}, byte_word[7:0]};
            F3_LBU:  load_ext = {24'd0, byte_word[7:0]};
            F3_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  load_ext = {16'd0, half_sel};
            F3_LW:   load_ext = sram_rdata;
            default: load_ext = 32'd0;
        endcase
    end

    assign rsp_rdata = (state_q == DONE && !store_q && !reset) ? load_ext : 32'd0;

endmodule
